// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV64M divider.
// Optional feature macro: DIV_EARLY_OUT_EN (see div_unit.sv).
package div_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   // Two's-complement magnitude for signed operands; unsigned values pass through.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one,
// then subtract the divisor when the partial remainder allows it.
module div_step
   import div_pkg::*;
(
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] partial;

   // The shifted remainder needs one extra bit before the compare.
   always_comb begin
      partial = {rem, quo[XLEN-1]};
      if (partial >= {1'b0, divisor}) begin
         rem_next = partial[XLEN-1:0] - divisor;
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = partial[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU) with start/busy/done handshake.
// Divide-by-zero returns the RISC-V mandated result in the cycle after start.
// Optional macro DIV_EARLY_OUT_EN: when |A| < |B| the answer is known up
// front (quotient 0, remainder A) and is returned on the same short path.
module div_unit
   import div_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   state_t           state, state_nxt;
   logic             sel_rem, sel_rem_nxt;
   logic             q_neg, q_neg_nxt;
   logic             r_neg, r_neg_nxt;
   logic [XLEN-1:0]  divisor, divisor_nxt;
   logic [XLEN-1:0]  rem, rem_nxt;
   logic [XLEN-1:0]  quo, quo_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [XLEN-1:0]  result_nxt;
   logic             done_nxt, div_by_zero_nxt;
   logic [XLEN-1:0]  mag_a, mag_b;
   logic [XLEN-1:0]  step_rem, step_quo;
   logic             op_signed;

   assign op_signed = ~op[0];
   assign mag_a     = magnitude(A, op_signed);
   assign mag_b     = magnitude(B, op_signed);
   assign busy      = (state != IDLE);

   div_step u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Register the FSM state and the whole datapath; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel_rem     <= 1'b0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         divisor     <= '0;
         rem         <= '0;
         quo         <= '0;
         count       <= '0;
         result      <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         sel_rem     <= sel_rem_nxt;
         q_neg       <= q_neg_nxt;
         r_neg       <= r_neg_nxt;
         divisor     <= divisor_nxt;
         rem         <= rem_nxt;
         quo         <= quo_nxt;
         count       <= count_nxt;
         result      <= result_nxt;
         done        <= done_nxt;
         div_by_zero <= div_by_zero_nxt;
      end
   end

   // Next-state and datapath logic: accept in IDLE, iterate in CALC, sign-fix in FIX.
   always_comb begin
      state_nxt       = state;
      sel_rem_nxt     = sel_rem;
      q_neg_nxt       = q_neg;
      r_neg_nxt       = r_neg;
      divisor_nxt     = divisor;
      rem_nxt         = rem;
      quo_nxt         = quo;
      count_nxt       = count;
      result_nxt      = result;
      done_nxt        = 1'b0;
      div_by_zero_nxt = div_by_zero;

      case (state)
         IDLE: begin
            if (start) begin
               sel_rem_nxt = op[1];
               if (B == '0) begin
                  result_nxt      = op[1] ? A : '1;
                  div_by_zero_nxt = 1'b1;
                  done_nxt        = 1'b1;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (mag_a < mag_b) begin
                  result_nxt      = op[1] ? A : '0;
                  div_by_zero_nxt = 1'b0;
                  done_nxt        = 1'b1;
               end
`endif
               else begin
                  divisor_nxt = mag_b;
                  quo_nxt     = mag_a;
                  rem_nxt     = '0;
                  q_neg_nxt   = op_signed & (A[XLEN-1] ^ B[XLEN-1]);
                  r_neg_nxt   = op_signed & A[XLEN-1];
                  count_nxt   = CNT_W'(XLEN - 1);
                  state_nxt   = CALC;
               end
            end
         end
         CALC: begin
            rem_nxt   = step_rem;
            quo_nxt   = step_quo;
            count_nxt = count - CNT_W'(1);
            if (count == '0) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            if (sel_rem) begin
               result_nxt = r_neg ? -rem : rem;
            end else begin
               result_nxt = q_neg ? -quo : quo;
            end
            done_nxt        = 1'b1;
            div_by_zero_nxt = 1'b0;
            state_nxt       = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, handshake and
// reset scenarios, then randomized operations against a arithmetic model.
// Latency is counted in clock edges after the edge that samples start.
module tb_div_unit;
   import div_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      op = 2'b00;
   logic [XLEN-1:0] A = '0;
   logic [XLEN-1:0] B = '0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            div_by_zero;

   int checks = 0;
   int errors = 0;

   div_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  o;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        dbz;
   } dir_t;

   dir_t dirs [12] = '{
      '{OP_DIVU, 64'd100, 64'd7, 64'd14, 1'b0},
      '{OP_REMU, 64'd100, 64'd7, 64'd2, 1'b0},
      '{OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
      '{OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
      '{OP_REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0},
      '{OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
      '{OP_REM,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1},
      '{OP_DIV,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
      '{OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0},
      '{OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0},
      '{OP_DIVU, 64'd3, 64'd10, 64'd0, 1'b0},
      '{OP_REMU, 64'd3, 64'd10, 64'd3, 1'b0}
   };

   // Magnitude of an operand as the instruction interprets it.
   function automatic logic [63:0] ref_mag(input logic [63:0] v, input logic [1:0] o);
      if (!o[0] && v[63]) return 64'd0 - v;
      return v;
   endfunction

   // Architectural result of a RV64M divide/remainder instruction.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ma, mb, q, r;
      if (b == 64'd0) return o[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      ma = ref_mag(a, o);
      mb = ref_mag(b, o);
      q  = ma / mb;
      r  = ma % mb;
      if (!o[0] && (a[63] != b[63])) q = 64'd0 - q;
      if (!o[0] && a[63]) r = 64'd0 - r;
      return o[1] ? r : q;
   endfunction

   // Edges from the start-sampling edge to the edge that registers done.
   function automatic int expected_edges(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      if (b == 64'd0) return 0;
`ifdef DIV_EARLY_OUT_EN
      if (ref_mag(a, o) < ref_mag(b, o)) return 0;
`endif
      return XLEN + 1;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      op    = o;
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; leaves the bench sampling inside the done cycle.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      while (!done && edges < 200) begin
         if (busy) busy_cycles++;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [1:0] o, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] exp_res, input logic exp_dbz);
      int edges, busy_cycles, exp_edges;
      exp_edges = expected_edges(o, a, b);
      apply_stimulus(o, a, b);
      wait_done(edges, busy_cycles);
      check_output({tag, "_done"}, 64'(done), 64'd1);
      check_output({tag, "_result"}, result, exp_res);
      check_output({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
      check_output({tag, "_latency"}, 64'(edges), 64'(exp_edges));
      check_output({tag, "_busy_cycles"}, 64'(busy_cycles), (exp_edges == 0) ? 64'd0 : 64'd65);
      check_output({tag, "_busy_at_done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int edges, busy_cycles, seen;
      logic [1:0]  ro;
      logic [63:0] ra, rb;

      $display("[TB] div_unit bench starting");

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_result", result, 64'd0);
      check_output("reset_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corner cases; each new start lands in the previous done cycle
      for (int i = 0; i < 12; i++) begin
         run_and_check($sformatf("dir%0d", i), dirs[i].o, dirs[i].a, dirs[i].b, dirs[i].res, dirs[i].dbz);
      end
      @(posedge clk);
      #1;
      check_output("done_single_pulse", 64'(done), 64'd0);

      // A start while busy must be ignored
      apply_stimulus(OP_DIVU, 64'd100, 64'd7);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
      end
      apply_stimulus(OP_DIVU, 64'd9, 64'd3);
      wait_done(edges, busy_cycles);
      check_output("busy_start_result", result, 64'd14);
      check_output("busy_start_latency", 64'(edges + 10), 64'd65);
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check_output("busy_start_no_extra_done", 64'(seen), 64'd0);
      check_output("busy_start_idle", 64'(busy), 64'd0);

      // Reset in the middle of an operation
      apply_stimulus(OP_DIVU, 64'd100, 64'd7);
      seen = 0;
      for (int i = 0; i < 29; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_output("abort_no_done", 64'(seen + int'(done)), 64'd0);
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_result", result, 64'd0);
      check_output("abort_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_and_check("after_abort", OP_DIVU, 64'd9, 64'd3, 64'd3, 1'b0);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0:       rb = 64'd0;
            1:       rb = 64'($urandom_range(1, 20));
            2:       rb = 64'd0 - 64'($urandom_range(1, 20));
            3: begin
               ra = 64'($urandom_range(0, 50));
               rb = 64'($urandom_range(51, 1000));
            end
            default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
         endcase
         run_and_check($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb), rb == 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
